frame_bank_scheduler: RTL and testbench

FRAME_BANK_SCHEDULER -- requirements
Module: frame_bank_scheduler

---
 rtl/frame_bank_scheduler.sv | 140 ++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - double-buffered video frame bank fill/swap scheduler
//
// Purpose: requests one frame of CELL_COUNT bits at a time from the data FSM,
// writes them into the bank not being displayed, and swaps banks when the
// display finishes a frame and the other bank holds a complete frame.
//
// Ports:
//   CLK_40               in   system clock
//   reset                in   asynchronous active-high reset
//   data_clk_rising_edge in   one-cycle data-clock sample qualifier
//   video_data_ready     in   data FSM presents a valid bit
//   frame_done           in   one-cycle pulse, display finished the read bank
//   start_req            out  one-cycle pulse, request one frame transfer
//   write_en             out  write strobe for the current bit
//   write_addr           out  cell index within write_bank
//   write_bank           out  bank being filled (always ~read_bank)
//   read_bank            out  bank being displayed
//   frame_valid          out  read_bank holds a complete frame
//   underrun             out  sticky, frame_done with nothing to swap to
//   timeout_err          out  sticky, a fill was aborted by the timeout

module frame_bank_scheduler #(
  parameter int CELL_COUNT = 23,
  parameter int TIMEOUT    = 40000,
  parameter int ADDR_W     = 5
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              data_clk_rising_edge,
  input  logic              video_data_ready,
  input  logic              frame_done,
  output logic              start_req,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_bank,
  output logic              read_bank,
  output logic              frame_valid,
  output logic              underrun,
  output logic              timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_COUNT - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);

  if (CELL_COUNT > (1 << ADDR_W)) begin : g_bad_cfg
    $error("frame_bank_scheduler: CELL_COUNT does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {IDLE, REQUEST, FILLING, COMMIT} state_t;

  state_t            r_state;
  logic [1:0]        r_bank_valid;
  logic              r_read_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [TW-1:0]     r_tcount;
  logic              r_start_req;
  logic              r_underrun;
  logic              r_timeout_err;

  logic       w_write_bank;
  logic       w_accept;
  logic       w_swap;
  logic [1:0] w_bank_valid_nxt;

  assign w_write_bank = ~r_read_bank;
  assign w_accept     = (r_state == FILLING) & video_data_ready & data_clk_rising_edge;
  // The bank finishing in COMMIT counts as complete for a coincident frame_done.
  assign w_swap       = frame_done & (r_bank_valid[w_write_bank] | (r_state == COMMIT));

  always_comb begin
    w_bank_valid_nxt = r_bank_valid;
    if (r_state == COMMIT) w_bank_valid_nxt[w_write_bank] = 1'b1;
    // The bank leaving the display becomes writable again.
    if (w_swap)            w_bank_valid_nxt[r_read_bank]  = 1'b0;
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bank_valid  <= 2'b00;
      r_read_bank   <= 1'b0;
      r_addr        <= '0;
      r_tcount      <= '0;
      r_start_req   <= 1'b0;
      r_underrun    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_bank_valid <= w_bank_valid_nxt;
      if (w_swap) begin
        r_read_bank <= ~r_read_bank;
      end else if (frame_done) begin
        r_underrun  <= 1'b1;
      end

      r_start_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_bank_valid[w_write_bank]) begin
            r_state     <= REQUEST;
            r_start_req <= 1'b1;
          end
        end
        REQUEST: begin
          r_addr   <= '0;
          r_tcount <= '0;
          r_state  <= FILLING;
        end
        FILLING: begin
          if (w_accept) begin
            r_tcount <= '0;
            if (r_addr == LAST_ADDR) r_state <= COMMIT;
            else                     r_addr  <= r_addr + 1'b1;
          end else if (r_tcount == TO_LAST) begin
            // Abort the partial frame; IDLE re-requests the same bank.
            r_timeout_err <= 1'b1;
            r_addr        <= '0;
            r_state       <= IDLE;
          end else begin
            r_tcount <= r_tcount + 1'b1;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_req   = r_start_req;
  assign write_en    = w_accept;
  assign write_addr  = r_addr;
  assign write_bank  = w_write_bank;
  assign read_bank   = r_read_bank;
  assign frame_valid = r_bank_valid[r_read_bank];
  assign underrun    = r_underrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - self-checking bench for frame_bank_scheduler

module tb_frame_bank_scheduler;

  localparam int CC = 4;
  localparam int TO = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dce = 1'b0;
  logic          rdy = 1'b0;
  logic          fd  = 1'b0;
  logic          start_req, write_en, write_bank, read_bank;
  logic          frame_valid, underrun, timeout_err;
  logic [AW-1:0] write_addr;

  frame_bank_scheduler #(.CELL_COUNT(CC), .TIMEOUT(TO), .ADDR_W(AW)) dut (
    .CLK_40(clk), .reset(rst), .data_clk_rising_edge(dce),
    .video_data_ready(rdy), .frame_done(fd), .start_req(start_req),
    .write_en(write_en), .write_addr(write_addr), .write_bank(write_bank),
    .read_bank(read_bank), .frame_valid(frame_valid), .underrun(underrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 waiting for a free bank, 1 request issued,
  // 2 collecting bits, 3 frame just completed.
  int m_phase = 0;
  int m_addr  = 0;
  int m_idle  = 0;
  bit m_valid [2];
  bit m_rb    = 0;
  bit m_under = 0;
  bit m_terr  = 0;
  int n_start = 0;
  int wr_q[$];

  always @(negedge clk) begin
    bit acc, wb, swap;
    if (rst) begin
      m_phase = 0; m_addr = 0; m_idle = 0;
      m_valid[0] = 0; m_valid[1] = 0;
      m_rb = 0; m_under = 0; m_terr = 0;
    end
    acc = !rst && (m_phase == 2) && rdy && dce;
    wb  = !m_rb;
    chk("start_req",   start_req,   m_phase == 1);
    chk("write_en",    write_en,    acc);
    chk("write_addr",  write_addr,  m_addr);
    chk("write_bank",  write_bank,  wb);
    chk("read_bank",   read_bank,   m_rb);
    chk("frame_valid", frame_valid, m_valid[m_rb]);
    chk("underrun",    underrun,    m_under);
    chk("timeout_err", timeout_err, m_terr);
    if (!rst) begin
      if (start_req) n_start++;
      if (write_en) wr_q.push_back(int'(write_bank) * 16 + int'(write_addr));
      swap = fd && (m_valid[wb] || m_phase == 3);
      case (m_phase)
        0: if (!m_valid[wb]) m_phase = 1;
        1: begin m_addr = 0; m_idle = 0; m_phase = 2; end
        2: begin
          if (acc) begin
            m_idle = 0;
            if (m_addr == CC - 1) m_phase = 3;
            else m_addr++;
          end else if (m_idle == TO - 1) begin
            m_terr = 1; m_addr = 0; m_phase = 0;
          end else begin
            m_idle++;
          end
        end
        default: begin m_valid[wb] = 1; m_phase = 0; end
      endcase
      if (swap) begin
        m_valid[m_rb] = 0;
        m_rb = !m_rb;
      end else if (fd) begin
        m_under = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start_req && n < 60) begin
      tick();
      n++;
    end
    if (!start_req) begin
      checks++;
      errors++;
      $display("FAIL %s: start_req not seen within 60 cycles, got 0 expected 1", tag);
    end
  endtask

  task automatic accept_n(input int k, input int gap);
    for (int i = 0; i < k; i++) begin
      dce = 1'b1;
      tick();
      dce = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic pulse_fd();
    fd = 1'b1;
    tick();
    fd = 1'b0;
  endtask

  initial begin
    int s0;
    rdy = 1'b1;
    repeat (3) tick();
    chk("rst_start_req", start_req, 0);
    chk("rst_write_bank", write_bank, 1);
    chk("rst_read_bank", read_bank, 0);
    chk("rst_frame_valid", frame_valid, 0);
    rst = 1'b0;

    // First fill of bank 1, accepts spaced 3 cycles.
    tick();
    chk("first_req_after_reset", start_req, 1);
    tick();
    accept_n(CC, 2);
    chk("fill1_nstart", n_start, 1);
    chk("fill1_nwrites", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("fill1_write", wr_q[i], 16 + i);
    chk("fill1_bank_valid", dut.r_bank_valid, 2'b10);
    chk("fill1_frame_valid", frame_valid, 0);
    // Stray accept while idle must be ignored.
    accept_n(1, 3);
    chk("idle_no_write", wr_q.size(), 4);
    chk("idle_addr_hold", write_addr, 3);
    chk("idle_nstart", n_start, 1);

    // Swap to bank 1, then fill bank 0 with frame_done in the commit cycle.
    pulse_fd();
    chk("swap1_read_bank", read_bank, 1);
    chk("swap1_frame_valid", frame_valid, 1);
    chk("swap1_bank_valid", dut.r_bank_valid, 2'b10);
    wait_start("req_bank0");
    chk("req_bank0_write_bank", write_bank, 0);
    tick();
    accept_n(CC - 1, 2);
    accept_n(1, 0);
    pulse_fd();
    chk("bypass_read_bank", read_bank, 0);
    chk("bypass_bank_valid", dut.r_bank_valid, 2'b01);
    chk("bypass_underrun", underrun, 0);
    chk("bypass_frame_valid", frame_valid, 1);

    // frame_done while filling bank 1 gives underrun; fill still completes.
    wait_start("req_bank1");
    tick();
    accept_n(2, 2);
    pulse_fd();
    chk("mid_fill_underrun", underrun, 1);
    chk("mid_fill_read_bank", read_bank, 0);
    accept_n(2, 2);
    chk("both_bank_valid", dut.r_bank_valid, 2'b11);

    // Timeout: swap frees bank 0, start filling and stall.
    pulse_fd();
    chk("swap2_bank_valid", dut.r_bank_valid, 2'b10);
    wait_start("req_to");
    tick();
    s0 = n_start;
    accept_n(2, 0);
    repeat (TO - 1) tick();
    chk("to_not_yet", timeout_err, 0);
    chk("to_addr_before", write_addr, 2);
    tick();
    chk("to_err", timeout_err, 1);
    chk("to_addr_cleared", write_addr, 0);
    chk("to_bank_valid", dut.r_bank_valid, 2'b10);
    chk("to_no_extra_req", n_start, s0);
    wait_start("req_retry");
    tick();
    chk("retry_nstart", n_start, s0 + 1);

    // Asynchronous reset mid-fill at address 2.
    accept_n(2, 1);
    chk("pre_rst_addr", write_addr, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_start_req", start_req, 0);
    chk("arst_write_en", write_en, 0);
    chk("arst_write_addr", write_addr, 0);
    chk("arst_write_bank", write_bank, 1);
    chk("arst_read_bank", read_bank, 0);
    chk("arst_frame_valid", frame_valid, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_timeout_err", timeout_err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_req", start_req, 1);
    tick();
    chk("post_rst_addr", write_addr, 0);
    accept_n(1, 0);
    chk("post_rst_write", wr_q[wr_q.size() - 1], 16);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
